// File: rtl/ft_stream_demux_if.sv
// Stream bundle between the FTDI receive side and the demux: incoming words, FIFO write port,
// CPU write port and the active-destination full flag.
interface ft_stream_demux_if #(
  parameter int unsigned FT_DATA_WIDTH = 32,
  parameter int unsigned IQ_HALF_WIDTH = 12,
  parameter int unsigned NUM_CH        = 4
);
  logic [FT_DATA_WIDTH-1:0]   data_i;
  logic                       we_i;
  logic [NUM_CH-1:0]          fifo_full_i;
  logic [2*IQ_HALF_WIDTH-1:0] fifo_data_o;
  logic [NUM_CH-1:0]          fifo_we_o;
  logic [FT_DATA_WIDTH-1:0]   cpu_data_o;
  logic                       cpu_we_o;
  logic                       full_o;

  modport master (
    output data_i, we_i, fifo_full_i,
    input  fifo_data_o, fifo_we_o, cpu_data_o, cpu_we_o, full_o
  );

  modport slave (
    input  data_i, we_i, fifo_full_i,
    output fifo_data_o, fifo_we_o, cpu_data_o, cpu_we_o, full_o
  );
endinterface

// File: rtl/ft_stream_demux.sv
// Packet-aware FTDI receive demux: decodes sync/channel/length headers and routes payload words
// to IQ FIFOs or the CPU port, with overflow tracking, bad-header counting and loopback bypass.
module ft_stream_demux #(
  parameter int unsigned FT_DATA_WIDTH    = 32,
  parameter int unsigned IQ_HALF_WIDTH    = 12,
  parameter int unsigned QSTART_BIT_INDEX = 16,
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned LEN_WIDTH        = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n,
  input  logic                 loopback,
  ft_stream_demux_if.slave     bus,
  output logic [NUM_CH-1:0]    overflow_o,
  input  logic                 ovf_clr_i,
  output logic [7:0]           hdr_err_cnt_o,
  output logic                 busy_o
);

  localparam logic [3:0]        SyncWord = 4'hA;
  localparam logic [3:0]        CpuId    = 4'hF;
  localparam logic [NUM_CH-1:0] ChZero   = NUM_CH'(1);

  typedef enum logic [1:0] {StDecode, StPayload, StLoop} state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 dest_q, dest_d;
  logic [LEN_WIDTH-1:0]       rem_q, rem_d;
  logic [2*IQ_HALF_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [NUM_CH-1:0]          fifo_we_q, fifo_we_d;
  logic [FT_DATA_WIDTH-1:0]   cpu_data_q, cpu_data_d;
  logic                       cpu_we_q, cpu_we_d;
  logic [NUM_CH-1:0]          ovf_q, ovf_d, ovf_set;
  logic [7:0]                 hdr_cnt_q, hdr_cnt_d;

  logic [3:0]                 hdr_sync, hdr_id;
  logic [LEN_WIDTH-1:0]       hdr_len;
  logic [2*IQ_HALF_WIDTH-1:0] packed_word;
  logic [NUM_CH-1:0]          dest_oh;
  logic                       dest_is_fifo;

  assign hdr_sync    = bus.data_i[FT_DATA_WIDTH-1 -: 4];
  assign hdr_id      = bus.data_i[FT_DATA_WIDTH-5 -: 4];
  assign hdr_len     = bus.data_i[LEN_WIDTH-1:0];
  assign packed_word = {bus.data_i[QSTART_BIT_INDEX +: IQ_HALF_WIDTH],
                        bus.data_i[IQ_HALF_WIDTH-1:0]};

  // Out-of-range channel IDs shift the bit out entirely, which marks them as DROP.
  assign dest_oh      = ChZero << dest_q;
  assign dest_is_fifo = |dest_oh;

  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    rem_d       = rem_q;
    fifo_we_d   = '0;
    fifo_data_d = fifo_data_q;
    cpu_we_d    = 1'b0;
    cpu_data_d  = cpu_data_q;
    ovf_set     = '0;
    hdr_cnt_d   = hdr_cnt_q;

    case (state_q)
      StLoop: begin
        if (bus.we_i) begin
          if (bus.fifo_full_i[0]) begin
            ovf_set = ChZero;
          end else begin
            fifo_we_d   = ChZero;
            fifo_data_d = packed_word;
          end
        end
        if (!loopback) state_d = StDecode;
      end

      StPayload: begin
        if (loopback) begin
          state_d = StLoop;
          rem_d   = '0;
        end else if (bus.we_i) begin
          if (dest_is_fifo) begin
            if ((bus.fifo_full_i & dest_oh) != '0) begin
              ovf_set = dest_oh;
            end else begin
              fifo_we_d   = dest_oh;
              fifo_data_d = packed_word;
            end
          end else if (dest_q == CpuId) begin
            cpu_we_d   = 1'b1;
            cpu_data_d = bus.data_i;
          end
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = StDecode;
        end
      end

      default: begin
        if (loopback) begin
          state_d = StLoop;
          rem_d   = '0;
        end else if (bus.we_i) begin
          if (hdr_sync != SyncWord) begin
            if (hdr_cnt_q != 8'hFF) hdr_cnt_d = hdr_cnt_q + 8'd1;
          end else begin
            dest_d = hdr_id;
            rem_d  = hdr_len;
            if (hdr_id == CpuId) begin
              cpu_we_d   = 1'b1;
              cpu_data_d = bus.data_i;
            end
            if (hdr_len != '0) state_d = StPayload;
          end
        end
      end
    endcase

    // A new drop in the same cycle as a clear must survive.
    ovf_d = (ovf_q & ~{NUM_CH{ovf_clr_i}}) | ovf_set;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StDecode;
      dest_q      <= '0;
      rem_q       <= '0;
      fifo_data_q <= '0;
      fifo_we_q   <= '0;
      cpu_data_q  <= '0;
      cpu_we_q    <= 1'b0;
      ovf_q       <= '0;
      hdr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      rem_q       <= rem_d;
      fifo_data_q <= fifo_data_d;
      fifo_we_q   <= fifo_we_d;
      cpu_data_q  <= cpu_data_d;
      cpu_we_q    <= cpu_we_d;
      ovf_q       <= ovf_d;
      hdr_cnt_q   <= hdr_cnt_d;
    end
  end

  always_comb begin
    bus.full_o = 1'b0;
    if (state_q == StPayload && dest_is_fifo) begin
      bus.full_o = (bus.fifo_full_i & dest_oh) != '0;
    end else if (state_q == StLoop) begin
      bus.full_o = bus.fifo_full_i[0];
    end
  end

  assign bus.fifo_data_o = fifo_data_q;
  assign bus.fifo_we_o   = fifo_we_q;
  assign bus.cpu_data_o  = cpu_data_q;
  assign bus.cpu_we_o    = cpu_we_q;
  assign overflow_o      = ovf_q;
  assign hdr_err_cnt_o   = hdr_cnt_q;
  assign busy_o          = state_q != StDecode;

endmodule
